led_rate_ctrl: RTL

//   Rate scheduler for the 8-bit LED counter. Owns the push button and produces a one-cycle count enable.

---
 rtl/led_rate_pkg.sv | 13 +
 rtl/btn_debounce.sv | 41 ++++
 rtl/led_rate_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/led_rate_pkg.sv
// led_rate_pkg: mode encoding and helpers shared by the LED rate scheduler blocks.
package led_rate_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_1S   = 2'd0;
  localparam mode_t MODE_HALF = 2'd1;
  localparam mode_t MODE_QTR  = 2'd2;
  function automatic mode_t next_mode(input mode_t m);
    return (m == MODE_1S) ? MODE_HALF : (m == MODE_HALF) ? MODE_QTR : MODE_1S;
  endfunction
  function automatic int unsigned period_of(input mode_t m, input int unsigned clk_hz);
    return clk_hz >> m;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-count debounce and registered rise/fall pulses.
module btn_debounce #(
  parameter int unsigned DB_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int unsigned CW = $clog2(DB_CYC + 1);
  logic s1_q, s2_q, lvl_q, lvl_d, rise_q, fall_q, diff, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    diff  = s2_q != lvl_q;
    hit   = diff && cnt_q == CW'(DB_CYC - 1);
    cnt_d = (diff && !hit) ? cnt_q + 1'b1 : '0;
    lvl_d = hit ? s2_q : lvl_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end
  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

// File: rtl/led_rate_ctrl.sv
// led_rate_ctrl: button-driven tick-rate scheduler for the LED counter.
// Optional long-press pause is built when LED_RATE_PAUSE_EN is defined.
module led_rate_ctrl
  import led_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 10_000_000,
  parameter int unsigned DB_CYC   = 1000,
  parameter int unsigned LONG_CYC = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_button,
  output logic       tick,
  output logic [1:0] mode,
  output logic       mode_chg,
  output logic       paused
);
  localparam int unsigned PW = $clog2(CLK_HZ);
  logic btn_db, btn_rise, btn_fall, adv, term;
  logic chg_q, chg_d, paused_q, paused_d;
  mode_t mode_q, mode_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  btn_debounce #(.DB_CYC(DB_CYC)) u_db (
    .clk   (clk),
    .rst   (rst),
    .din   (push_button),
    .level (btn_db),
    .rise  (btn_rise),
    .fall  (btn_fall)
  );
`ifdef LED_RATE_PAUSE_EN
  localparam int unsigned HW = $clog2(LONG_CYC + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic long_q, long_d, long_hit, unused_in;
  assign unused_in = btn_rise;
  // a long hold toggles pause and swallows the mode advance of its release
  always_comb begin
    long_hit = btn_db && !long_q && hold_q == HW'(LONG_CYC - 1);
    hold_d   = !btn_db ? '0 : (hold_q < HW'(LONG_CYC)) ? hold_q + 1'b1 : hold_q;
    long_d   = btn_db && (long_q || long_hit);
    paused_d = paused_q ^ long_hit;
    adv      = btn_fall && !long_q && !paused_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end
`else
  logic unused_in;
  assign unused_in = btn_db ^ btn_fall ^ (LONG_CYC == 0);
  assign paused_d  = 1'b0;
  assign adv       = btn_rise;
`endif
  // the mode_chg cycle restarts the period and never emits a tick
  always_comb begin
    term   = pcnt_q == PW'(period_of(mode_q, CLK_HZ) - 1);
    tick   = term && !chg_q && !paused_q;
    pcnt_d = chg_q ? '0 : paused_q ? pcnt_q : term ? '0 : pcnt_q + 1'b1;
    mode_d = adv ? next_mode(mode_q) : mode_q;
    chg_d  = adv;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_1S;
      chg_q    <= 1'b0;
      pcnt_q   <= '0;
      paused_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      chg_q    <= chg_d;
      pcnt_q   <= pcnt_d;
      paused_q <= paused_d;
    end
  end
  assign mode     = mode_q;
  assign mode_chg = chg_q;
  assign paused   = paused_q;
endmodule
